// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, imem handshake, op_en issue, halt/fault detection
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] op,
   output logic        op_en,
   output logic [31:0] pc,
   input  logic        ex_end,
   input  logic [31:0] next_pc,
   input  logic        ebreak_flag,
   output logic        halted,
   output logic        fetch_fault,
   output logic [31:0] fault_pc,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {FETCH, WAIT_RESP, WAIT_EX, HALT, FAULT} state_t;

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;

   state_t      state;
   logic        ex_end_q;
   logic [31:0] tmo_cnt;
   logic        tmo_hit;

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   // Counter starts at 0 on entry, so the TIMEOUT-th cycle in a wait state is the one that faults.
   assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         op          <= '0;
         op_en       <= 1'b0;
         halted      <= 1'b0;
         fetch_fault <= 1'b0;
         fault_pc    <= '0;
         instret     <= '0;
         ex_end_q    <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         op_en <= 1'b0;
         if (state != WAIT_EX)
            ex_end_q <= ex_end;
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  state   <= WAIT_RESP;
                  tmo_cnt <= '0;
               end
            end
            WAIT_RESP: begin
               if (imem_rvalid) begin
                  op      <= imem_rdata;
                  op_en   <= 1'b1;
                  state   <= WAIT_EX;
                  tmo_cnt <= '0;
               end else if (tmo_hit) begin
                  state       <= FAULT;
                  fetch_fault <= 1'b1;
                  fault_pc    <= pc;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            WAIT_EX: begin
               if (ex_end != ex_end_q) begin
                  ex_end_q <= ex_end;
                  instret  <= instret + 32'd1;
                  if (ebreak_flag) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else if (next_pc[1:0] != 2'b00) begin
                     state       <= FAULT;
                     fetch_fault <= 1'b1;
                     fault_pc    <= next_pc;
                  end else begin
                     pc    <= next_pc;
                     state <= FETCH;
                  end
               end else if (tmo_hit) begin
                  state       <= FAULT;
                  fetch_fault <= 1'b1;
                  fault_pc    <= pc;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - scoreboard testbench for ifu
module tb_ifu;
   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] op;
   logic        op_en;
   logic [31:0] pc;
   logic        ex_end = 1'b0;
   logic [31:0] next_pc = '0;
   logic        ebreak_flag = 1'b0;
   logic        halted;
   logic        fetch_fault;
   logic [31:0] fault_pc;
   logic [31:0] instret;

   int tests = 0;
   int failed = 0;
   int req_cycles = 0;
   int op_en_cnt = 0;
   logic [31:0] exp_addr[$];
   logic [63:0] exp_op[$];

   ifu #(.RESET_PC(RPC), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .op(op), .op_en(op_en), .pc(pc),
      .ex_end(ex_end), .next_pc(next_pc), .ebreak_flag(ebreak_flag),
      .halted(halted), .fetch_fault(fetch_fault), .fault_pc(fault_pc), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every accepted request and every op_en pulse against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (imem_req) req_cycles++;
         if (imem_req && imem_ready) begin
            if (exp_addr.size() == 0) chk("unexpected_req_addr", imem_addr, 32'hxxxx_xxxx);
            else chk("req_addr", imem_addr, exp_addr.pop_front());
         end
         if (op_en) begin
            logic [63:0] e;
            op_en_cnt++;
            if (exp_op.size() == 0) chk("unexpected_op_en", op, 32'hxxxx_xxxx);
            else begin
               e = exp_op.pop_front();
               chk("op", op, e[63:32]);
               chk("op_pc", pc, e[31:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] a, input logic [31:0] d,
                           input int rdy_wait, input int rv_wait, input bit stray);
      exp_addr.push_back(a);
      exp_op.push_back({d, a});
      imem_ready = 1'b0;
      repeat (rdy_wait) step();
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      if (stray) ex_end = ~ex_end;
      repeat (rv_wait - 1) step();
      imem_rvalid = 1'b1;
      imem_rdata = d;
      step();
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
   endtask

   task automatic retire(input logic [31:0] npc, input bit eb);
      next_pc = npc;
      ebreak_flag = eb;
      ex_end = ~ex_end;
      step();
      ebreak_flag = 1'b0;
   endtask

   initial begin
      int rc;
      int oc;
      do_reset();
      chk("rst_pc", pc, RPC);
      chk("rst_op", op, 32'h0);
      chk("rst_op_en", {31'b0, op_en}, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'h0);
      chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      chk("rst_instret", instret, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h1);

      // Basic fetch: op_en must be high in cycle 2
      do_fetch(RPC, 32'h0010_0093, 0, 1, 1'b0);
      chk("basic_op_en_latency", {31'b0, op_en}, 32'h1);
      retire(32'h8000_0004, 1'b0);
      chk("basic_instret", instret, 32'd1);
      chk("basic_pc", pc, 32'h8000_0004);

      // Backpressure: 3 not-ready cycles plus the accept cycle
      rc = req_cycles;
      oc = op_en_cnt;
      do_fetch(32'h8000_0004, 32'h0020_0113, 3, 4, 1'b0);
      step();
      chk("bp_req_cycles", 32'(req_cycles - rc), 32'd4);
      chk("bp_one_op_en", 32'(op_en_cnt - oc), 32'd1);
      retire(32'h8000_0100, 1'b0);
      chk("branch_pc", pc, 32'h8000_0100);

      // Stray toggle in WAIT_RESP is discarded
      do_fetch(32'h8000_0100, 32'h0030_8193, 0, 3, 1'b1);
      chk("stray_instret", instret, 32'd2);
      chk("stray_pc", pc, 32'h8000_0100);

      // Halt
      retire(32'h8000_0104, 1'b1);
      chk("halt_flag", {31'b0, halted}, 32'h1);
      chk("halt_instret", instret, 32'd3);
      rc = req_cycles;
      oc = op_en_cnt;
      repeat (100) step();
      chk("halt_no_req", 32'(req_cycles - rc), 32'd0);
      chk("halt_no_op_en", 32'(op_en_cnt - oc), 32'd0);

      // Misaligned target
      do_reset();
      do_fetch(RPC, 32'h0000_0013, 0, 1, 1'b0);
      retire(32'h8000_0102, 1'b0);
      chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
      chk("mis_fault_pc", fault_pc, 32'h8000_0102);
      chk("mis_pc_kept", pc, RPC);
      chk("mis_instret", instret, 32'd1);
      chk("mis_req", {31'b0, imem_req}, 32'h0);

      // Response timeout with TIMEOUT = 8
      do_reset();
      exp_addr.push_back(RPC);
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      repeat (7) step();
      chk("tmo_not_yet", {31'b0, fetch_fault}, 32'h0);
      step();
      chk("tmo_fault", {31'b0, fetch_fault}, 32'h1);
      chk("tmo_fault_pc", fault_pc, RPC);

      // Reset mid WAIT_RESP with stale response
      do_reset();
      do_fetch(RPC, 32'h0000_0013, 0, 1, 1'b0);
      retire(32'h8000_0040, 1'b0);
      exp_addr.push_back(32'h8000_0040);
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst_pc", pc, RPC);
      chk("async_rst_instret", instret, 32'h0);
      chk("async_rst_req", {31'b0, imem_req}, 32'h1);
      imem_rvalid = 1'b1;
      imem_rdata = 32'hdead_beef;
      step();
      rst = 1'b0;
      step();
      imem_rvalid = 1'b0;
      chk("stale_op", op, 32'h0);
      do_fetch(RPC, 32'h0040_0213, 0, 1, 1'b0);
      retire(32'h8000_0004, 1'b0);
      chk("refetch_pc", pc, 32'h8000_0004);

      step();
      chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
      chk("op_queue_empty", 32'(exp_op.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the multi-cycle NPC core, sitting directly upstream of the execute unit. It holds the architectural PC and fetches one instruction word from instruction memory through a request/response handshake. It hands the word to the execute unit as a one-cycle `op_en` pulse, then waits for the execute unit's `ex_end` toggle before loading `next_pc` and fetching again. It also detects halt (`ebreak`), misaligned targets and memory/execute timeouts, and counts retired instructions.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `TIMEOUT`, default 1024: maximum cycles spent in WAIT_RESP or WAIT_EX before faulting; 0 disables the check.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `imem_req`  out  1  fetch request valid, combinational, = (state==FETCH).
- `imem_addr`  out  32  fetch address, = `pc`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  instruction word.
- `op`  out  32  instruction to the execute unit; held stable until the next fetch completes.
- `op_en`  out  1  one-cycle pulse: `op`/`pc` valid, start execution.
- `pc`  out  32  PC of `op`.
- `ex_end`  in  1  toggles once per completed instruction.
- `next_pc`  in  32  target PC from the execute unit; valid when `ex_end` toggles.
- `ebreak_flag`  in  1  execute unit saw `ebreak`; valid when `ex_end` toggles.
- `halted`  out  1  sticky; `ebreak` retired.
- `fetch_fault`  out  1  sticky; misaligned target or timeout.
- `fault_pc`  out  32  offending target PC (misalign) or current `pc` (timeout).
- `instret`  out  32  count of retired instructions.

## Operation
- States: FETCH, WAIT_RESP, WAIT_EX, HALT, FAULT.
- Reset values:
  - state = FETCH, `pc` = RESET_PC.
  - `op` = 0, `op_en` = 0, `halted` = 0, `fetch_fault` = 0, `fault_pc` = 0, `instret` = 0.
  - internal `ex_end_q` = 0, timeout counter = 0.
- FETCH: `imem_req` = 1. Leave on the posedge where `imem_req` && `imem_ready` → WAIT_RESP. `imem_req` stays high until accepted; no timeout applies in FETCH.
- WAIT_RESP: on `imem_rvalid`:
  - `op` <= `imem_rdata`, `op_en` <= 1, state → WAIT_EX.
  - `imem_rvalid` in any other state is ignored, which covers stale responses after reset.
- WAIT_EX: when `ex_end` != `ex_end_q`, then `ex_end_q` <= `ex_end` and `instret` <= `instret` + 1 (mod 2^32). Priority:
  1. `ebreak_flag` → HALT, `halted` <= 1.
  2. `next_pc[1:0]` != 0 → FAULT, `fetch_fault` <= 1, `fault_pc` <= `next_pc`, `pc` unchanged.
  3. Otherwise `pc` <= `next_pc`, → FETCH.
- Outside WAIT_EX, `ex_end_q` <= `ex_end` every cycle, so stray toggles are discarded.
- Timeout:
  - Counter clears on entry to WAIT_RESP and on entry to WAIT_EX, and increments each cycle in those states.
  - If the counter reaches TIMEOUT (and TIMEOUT != 0) before the exit condition → FAULT, `fault_pc` <= `pc`, `fetch_fault` <= 1.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- HALT and FAULT are terminal until `rst`. In both, `imem_req` = 0 and `op_en` = 0.
- Asynchronous `rst` mid-operation returns every register to its reset value immediately. The next fetch restarts from RESET_PC.

## Timing
- `op_en` is high for exactly the one cycle after the posedge that captured `rvalid`. It is never asserted twice for the same fetch.
- Minimum fetch latency, with `imem_ready` = 1 and `rvalid` one cycle after acceptance:
  - Cycle 0 (FETCH): request accepted.
  - Cycle 1 (WAIT_RESP): `rvalid` sampled.
  - Cycle 2: `op_en` = 1.
- Back-to-back: `imem_req` rises the cycle after the posedge that sampled the `ex_end` toggle.
- `pc` changes only on the WAIT_EX→FETCH transition, so it is stable throughout execution.
- `instret` and `halted`/`fetch_fault` update on the same edge that consumes the toggle.

## Test plan
- Basic fetch, RESET_PC = 0x8000_0000, zero-wait memory returning 0x00100093:
  - `imem_addr` = 0x8000_0000 in cycle 0; `op_en` pulse with `op` = 0x00100093 in cycle 2.
  - After an `ex_end` toggle with `next_pc` = 0x8000_0004, the next request goes to 0x8000_0004 and `instret` = 1.
- Backpressure: `imem_ready` low for 3 cycles, then `rvalid` 4 cycles after acceptance → `imem_req` held high for 4 cycles, exactly one `op_en`, `op` is correct.
- Branch and stray toggles:
  - `next_pc` = 0x8000_0100 → next fetch is at 0x8000_0100.
  - An `ex_end` toggle injected during WAIT_RESP neither advances `pc` nor `instret`.
- Halt: toggle with `ebreak_flag` = 1 → `halted` = 1, `instret` increments, `imem_req` stays 0 for 100 cycles, and no further `op_en`.
- Faults:
  - `next_pc` = 0x8000_0102 → `fetch_fault` = 1, `fault_pc` = 0x8000_0102.
  - Separately, with TIMEOUT = 8, withholding `rvalid` → fault after 8 cycles in WAIT_RESP, `fault_pc` = current `pc`.
- Reset mid-operation: assert `rst` in WAIT_RESP, deliver a stale `rvalid` during reset and the first FETCH cycle → outputs immediately at reset values, stale data ignored, refetch from RESET_PC.
